rc4_decrypt_master: RTL and testbench
=====================================

Name: rc4_decrypt_master

Overview:
Parametrised RC4 master state machine. Each run does three phases: S-box init, key scheduling (KSA), then PRGA decryption of an encrypted ROM into a decrypted RAM. Adds start/done handshake, configurable width/depth/key length/message length, and an optional plaintext validity check with early abort. Sits between the key-search controller and three on-chip memories (S RAM, encrypted ROM, decrypted RAM).

Parameters:
W, 8, word width; S RAM depth N = 2**W; all index arithmetic mod 2**W
KEY_BYTES, 3, number of W-bit key words
MSG_LEN, 32, message words decrypted per run (1..2**W)
CHECK_EN, 1, 1 = enable validity check and abort; 0 = key_ok forced 1 at done

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  run request, level; sampled in IDLE only
secret_key  in  W*KEY_BYTES  key[0] = most significant W bits; sampled on start acceptance
s_addr  out  W  S RAM address
s_data  out  W  S RAM write data
s_wren  out  1  S RAM write enable
s_q  in  W  S RAM read data, valid one cycle after address
rom_addr  out  W  encrypted ROM address
rom_q  in  W  ROM data, valid one cycle after address
d_addr  out  W  decrypted RAM address
d_data  out  W  decrypted word
d_wren  out  1  decrypted RAM write enable
busy  out  1  high from start acceptance until DONE
done  out  1  high in DONE
key_ok  out  1  result; valid only while done=1

Behaviour:
- Reset: state IDLE, all outputs 0, i=j=k=kidx=0. Reset mid-run aborts immediately. Memory contents are undefined afterwards.
- IDLE: start=1 latches the key, sets busy=1, clears i/j/kidx, and enters INIT. start is ignored in all other states.
- INIT: one write per cycle, S[i]=i for i=0..N-1 (N cycles, s_wren=1).
- KSA, 6 cycles per i, i=0..N-1:
  - K_RI: s_addr=i.
  - K_WI: wait.
  - K_RJ: si=s_q; j=j+si+key[kidx]; s_addr=new j.
  - K_WJ: wait.
  - K_SI: write S[i]=s_q (sj).
  - K_SJ: write S[j]=si.
  - kidx wraps at KEY_BYTES-1 by counter compare; no modulo operator.
  - i==j case: K_SJ must write si, leaving S[i] unchanged.
- PRGA: i=j=0 at entry. 9 cycles per k, k=0..MSG_LEN-1:
  - P_INC: i=i+1; s_addr=i; rom_addr=k.
  - P_WI: wait.
  - P_RJ: si=s_q; j=j+si; s_addr=j.
  - P_WJ: wait.
  - P_SI: sj=s_q; write S[i]=sj.
  - P_SJ: write S[j]=si.
  - P_RF: s_addr=si+sj.
  - P_WF: wait.
  - P_OUT: d_addr=k; d_data=s_q xor rom_q; d_wren=1.
  - rom_addr is held stable from P_INC through P_OUT.
- Check (CHECK_EN=1, W=8): a byte is valid if 0x61..0x7A or 0x20. An invalid byte is still written, then the block goes straight to DONE with key_ok=0. If all MSG_LEN words are valid, key_ok=1.
- Write enables are single-cycle; no read and write in the same cycle on a memory.
- DONE: done=1, busy=0, key_ok held. Stays in DONE while start=1; start=0 returns to IDLE next cycle (done, key_ok cleared).
- Latency, full run: done first high N + 6N + 9*MSG_LEN clock edges after the edge accepting start.
- Latency, abort at word m (0-based): done first high N + 6N + 9*(m+1) edges after acceptance.

Decomposition:
- rc4_pkg: state enum (IDLE, INIT, K_RI..K_SJ, P_INC..P_OUT, DONE), ASCII_LO=8'h61, ASCII_HI=8'h7A, ASCII_SP=8'h20.
- One sub-module, rc4_char_check: combinational W-bit validity flag, parameterised by CHECK_EN.

Test Plan:
- Bench memories use 1-cycle read latency models.
- W=8, KEY_BYTES=3, MSG_LEN=9, CHECK_EN=0, key 24'h4B6579, ROM BB F3 16 E8 D9 40 AF 0A D3 -> dec RAM 50 6C 61 69 6E 74 65 78 74; done at edge 1873; key_ok=1.
- Same vector, CHECK_EN=1 -> one d_wren (addr 0, 0x50); done at edge 1801; key_ok=0.
- CHECK_EN=1, ROM = key 4B6579 encryption of "abc xyz" padded with spaces to 9 words -> all 9 writes match; key_ok=1; done at edge 1873.
- Reset asserted at edge 500 (mid-KSA) -> next cycle all outputs 0, state IDLE. A fresh start then reproduces the first scenario exactly.
- Handshake: start held high 50 cycles after done -> done stays 1. start low -> done/key_ok 0 next cycle. start toggled during busy -> no effect on cycle count.
- W=4, KEY_BYTES=2, MSG_LEN=4, random key/ROM vs software RC4 model -> S RAM after INIT equals 0..15; dec RAM matches; done at edge 148.

Source files
------------

// File: rtl/rc4_decrypt_master_pkg.sv
// Shared types and constants for the RC4 decrypt master.
//   state_t  : master FSM states (init, 6-state KSA step, 9-state PRGA step)
//   ASCII_*  : bounds of the accepted plaintext alphabet (a..z and space)
//   is_text  : 1 when a byte lies in that alphabet
package rc4_decrypt_master_pkg;

  typedef enum logic [4:0] {
    IDLE,
    INIT,
    K_RI, K_WI, K_RJ, K_WJ, K_SI, K_SJ,
    P_INC, P_WI, P_RJ, P_WJ, P_SI, P_SJ, P_RF, P_WF, P_OUT,
    DONE
  } state_t;

  localparam logic [7:0] ASCII_LO = 8'h61;
  localparam logic [7:0] ASCII_HI = 8'h7A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  function automatic logic is_text(input logic [7:0] b);
    return ((b >= ASCII_LO) && (b <= ASCII_HI)) || (b == ASCII_SP);
  endfunction

endpackage

// File: rtl/rc4_decrypt_master_if.sv
// Bus bundle between the RC4 master, its controller and its three memories.
//   start/secret_key -> master; busy/done/key_ok <- master (controller side)
//   s_addr/s_data/s_wren/s_q : S RAM, 1-cycle read latency
//   rom_addr/rom_q           : encrypted ROM, 1-cycle read latency
//   d_addr/d_data/d_wren     : decrypted RAM write port
// modport master = the RC4 block, modport slave = controller + memories.
interface rc4_decrypt_master_if #(
  parameter int W         = 8,
  parameter int KEY_BYTES = 3
);
  logic                   start;
  logic [W*KEY_BYTES-1:0] secret_key;
  logic                   busy;
  logic                   done;
  logic                   key_ok;
  logic [W-1:0]           s_addr;
  logic [W-1:0]           s_data;
  logic                   s_wren;
  logic [W-1:0]           s_q;
  logic [W-1:0]           rom_addr;
  logic [W-1:0]           rom_q;
  logic [W-1:0]           d_addr;
  logic [W-1:0]           d_data;
  logic                   d_wren;

  modport master (
    input  start, secret_key, s_q, rom_q,
    output busy, done, key_ok, s_addr, s_data, s_wren, rom_addr, d_addr, d_data, d_wren
  );

  modport slave (
    output start, secret_key, s_q, rom_q,
    input  busy, done, key_ok, s_addr, s_data, s_wren, rom_addr, d_addr, d_data, d_wren
  );
endinterface

// File: rtl/rc4_decrypt_master_char_check.sv
// Combinational plaintext validity flag.
//   data  : decrypted W-bit word
//   valid : 1 if the word is a lowercase letter or space; tied to 1 when
//           CHECK_EN=0 so every key is reported as good.
module rc4_char_check
  import rc4_decrypt_master_pkg::*;
#(
  parameter int W        = 8,
  parameter int CHECK_EN = 1
)(
  input  logic [W-1:0] data,
  output logic         valid
);

  if (CHECK_EN == 0) begin : g_off
    logic unused_data;
    assign unused_data = ^data;
    assign valid       = 1'b1;
  end else if (W > 8) begin : g_wide
    // anything above the byte range can never be text
    assign valid = is_text(data[7:0]) && ~|data[W-1:8];
  end else if (W == 8) begin : g_byte
    assign valid = is_text(data);
  end else begin : g_narrow
    assign valid = is_text({{(8-W){1'b0}}, data});
  end

endmodule

// File: rtl/rc4_decrypt_master.sv
// RC4 master: S-box init, key scheduling, then PRGA decryption of MSG_LEN
// ROM words into the decrypted RAM, with optional early abort on the first
// non-text byte.
//   clk, reset : clock, synchronous active-high reset
//   bus        : rc4_decrypt_master_if.master (start/done handshake + memories)
// All bus outputs are registered. Each FSM state describes the register
// updates taken at the edge leaving it, so an address set in state X is
// on the bus in X+1 and its read data arrives in X+2.
module rc4_decrypt_master
  import rc4_decrypt_master_pkg::*;
#(
  parameter int W         = 8,
  parameter int KEY_BYTES = 3,
  parameter int MSG_LEN   = 32,
  parameter int CHECK_EN  = 1
)(
  input  logic                 clk,
  input  logic                 reset,
  rc4_decrypt_master_if.master bus
);

  localparam int              KW        = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [W-1:0]    I_LAST    = '1;
  localparam logic [W-1:0]    K_LAST    = W'(MSG_LEN - 1);
  localparam logic [KW-1:0]   KIDX_LAST = KW'(KEY_BYTES - 1);

  state_t        state;
  logic [W-1:0]  i, j, k, si, sj;
  logic [KW-1:0] kidx;
  logic [W-1:0]  key_r [KEY_BYTES];

  logic [W-1:0]  s_addr, s_data, rom_addr, d_addr, d_data;
  logic          s_wren, d_wren, busy, done, key_ok;

  logic [W-1:0]  j_ksa, j_prga, plain;
  logic          ok;

  assign j_ksa  = j + bus.s_q + key_r[kidx];
  assign j_prga = j + bus.s_q;
  assign plain  = bus.s_q ^ bus.rom_q;

  rc4_char_check #(.W(W), .CHECK_EN(CHECK_EN)) u_chk (.data(plain), .valid(ok));

  // key[0] is the most significant word; store it in natural index order
  always_ff @(posedge clk) begin
    if (!reset && state == IDLE && bus.start)
      for (int b = 0; b < KEY_BYTES; b++)
        key_r[b] <= bus.secret_key[(KEY_BYTES-1-b)*W +: W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      kidx     <= '0;
      si       <= '0;
      sj       <= '0;
      s_addr   <= '0;
      s_data   <= '0;
      s_wren   <= 1'b0;
      rom_addr <= '0;
      d_addr   <= '0;
      d_data   <= '0;
      d_wren   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      key_ok   <= 1'b0;
    end else begin
      // write enables are pulses; states that write re-assert them
      s_wren <= 1'b0;
      d_wren <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          busy   <= 1'b1;
          i      <= '0;
          j      <= '0;
          kidx   <= '0;
          s_addr <= '0;
          s_data <= '0;
          s_wren <= 1'b1;
          state  <= INIT;
        end
        INIT: begin
          if (i == I_LAST) begin
            i     <= '0;
            state <= K_RI;
          end else begin
            i      <= i + 1'b1;
            s_addr <= i + 1'b1;
            s_data <= i + 1'b1;
            s_wren <= 1'b1;
          end
        end
        K_RI: begin
          s_addr <= i;
          state  <= K_WI;
        end
        K_WI: state <= K_RJ;
        K_RJ: begin
          si     <= bus.s_q;
          j      <= j_ksa;
          s_addr <= j_ksa;
          kidx   <= (kidx == KIDX_LAST) ? '0 : kidx + 1'b1;
          state  <= K_WJ;
        end
        K_WJ: state <= K_SI;
        K_SI: begin
          s_addr <= i;
          s_data <= bus.s_q;
          s_wren <= 1'b1;
          state  <= K_SJ;
        end
        K_SJ: begin
          // writing the latched si keeps S[i] intact when i == j
          s_addr <= j;
          s_data <= si;
          s_wren <= 1'b1;
          if (i == I_LAST) begin
            i     <= '0;
            j     <= '0;
            k     <= '0;
            state <= P_INC;
          end else begin
            i     <= i + 1'b1;
            state <= K_RI;
          end
        end
        P_INC: begin
          i        <= i + 1'b1;
          s_addr   <= i + 1'b1;
          rom_addr <= k;
          state    <= P_WI;
        end
        P_WI: state <= P_RJ;
        P_RJ: begin
          si     <= bus.s_q;
          j      <= j_prga;
          s_addr <= j_prga;
          state  <= P_WJ;
        end
        P_WJ: state <= P_SI;
        P_SI: begin
          sj     <= bus.s_q;
          s_addr <= i;
          s_data <= bus.s_q;
          s_wren <= 1'b1;
          state  <= P_SJ;
        end
        P_SJ: begin
          s_addr <= j;
          s_data <= si;
          s_wren <= 1'b1;
          state  <= P_RF;
        end
        P_RF: begin
          s_addr <= si + sj;
          state  <= P_WF;
        end
        P_WF: state <= P_OUT;
        P_OUT: begin
          // the word is written even when it fails the check
          d_addr <= k;
          d_data <= plain;
          d_wren <= 1'b1;
          if (!ok || k == K_LAST) begin
            key_ok <= ok;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else begin
            k     <= k + 1'b1;
            state <= P_INC;
          end
        end
        DONE: if (!bus.start) begin
          done   <= 1'b0;
          key_ok <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_addr   = s_addr;
  assign bus.s_data   = s_data;
  assign bus.s_wren   = s_wren;
  assign bus.rom_addr = rom_addr;
  assign bus.d_addr   = d_addr;
  assign bus.d_data   = d_data;
  assign bus.d_wren   = d_wren;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.key_ok   = key_ok;

endmodule

// File: tb/tb_rc4_decrypt_master.sv
// Bench for rc4_decrypt_master. Three instances share clk/reset:
//   A: W=8 KEY_BYTES=3 MSG_LEN=9 CHECK_EN=1
//   B: W=8 KEY_BYTES=3 MSG_LEN=9 CHECK_EN=0
//   C: W=4 KEY_BYTES=2 MSG_LEN=4 CHECK_EN=0
// A plain software RC4 produces the keystream; expected decrypted-RAM writes
// are queued per run and popped by a monitor whenever any d_wren is seen.
module tb_rc4_decrypt_master;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rc4_decrypt_master_if #(.W(8), .KEY_BYTES(3)) ifa ();
  rc4_decrypt_master_if #(.W(8), .KEY_BYTES(3)) ifb ();
  rc4_decrypt_master_if #(.W(4), .KEY_BYTES(2)) ifc ();

  rc4_decrypt_master #(.W(8), .KEY_BYTES(3), .MSG_LEN(9), .CHECK_EN(1))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  rc4_decrypt_master #(.W(8), .KEY_BYTES(3), .MSG_LEN(9), .CHECK_EN(0))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));
  rc4_decrypt_master #(.W(4), .KEY_BYTES(2), .MSG_LEN(4), .CHECK_EN(0))
    dut_c (.clk(clk), .reset(reset), .bus(ifc));

  // ---------------- controller-side drives ----------------
  logic [2:0]  start_v;
  logic [23:0] key_a, key_b;
  logic [7:0]  key_c;
  assign ifa.start = start_v[0];
  assign ifb.start = start_v[1];
  assign ifc.start = start_v[2];
  assign ifa.secret_key = key_a;
  assign ifb.secret_key = key_b;
  assign ifc.secret_key = key_c;

  wire [2:0] busy_v = {ifc.busy,   ifb.busy,   ifa.busy};
  wire [2:0] done_v = {ifc.done,   ifb.done,   ifa.done};
  wire [2:0] kok_v  = {ifc.key_ok, ifb.key_ok, ifa.key_ok};

  // ---------------- memory models, 1-cycle read latency ----------------
  logic [7:0] sm_a [256], rom_a [256], dm_a [256];
  logic [7:0] sm_b [256], rom_b [256], dm_b [256];
  logic [3:0] sm_c [16],  rom_c [16],  dm_c [16];
  logic [7:0] sq_a, rq_a, sq_b, rq_b;
  logic [3:0] sq_c, rq_c;

  always @(posedge clk) begin
    if (ifa.s_wren) sm_a[ifa.s_addr] <= ifa.s_data;
    if (ifa.d_wren) dm_a[ifa.d_addr] <= ifa.d_data;
    sq_a <= sm_a[ifa.s_addr];
    rq_a <= rom_a[ifa.rom_addr];
    if (ifb.s_wren) sm_b[ifb.s_addr] <= ifb.s_data;
    if (ifb.d_wren) dm_b[ifb.d_addr] <= ifb.d_data;
    sq_b <= sm_b[ifb.s_addr];
    rq_b <= rom_b[ifb.rom_addr];
    if (ifc.s_wren) sm_c[ifc.s_addr] <= ifc.s_data;
    if (ifc.d_wren) dm_c[ifc.d_addr] <= ifc.d_data;
    sq_c <= sm_c[ifc.s_addr];
    rq_c <= rom_c[ifc.rom_addr];
  end
  assign ifa.s_q = sq_a;  assign ifa.rom_q = rq_a;
  assign ifb.s_q = sq_b;  assign ifb.rom_q = rq_b;
  assign ifc.s_q = sq_c;  assign ifc.rom_q = rq_c;

  // ---------------- bookkeeping ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int exp_q [$];      // {dut, addr, data} packed as dut<<16 | addr<<8 | data
  int ks [256];
  int rom_img [256];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon_pop(input int got);
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL dec_write: unexpected write 0x%0h, expected none", got);
    end else begin
      int e;
      e = exp_q.pop_front();
      if (e != got) begin
        n_fail++;
        $display("FAIL dec_write: got 0x%0h expected 0x%0h", got, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (ifa.d_wren) mon_pop((0 << 16) | (int'(ifa.d_addr) << 8) | int'(ifa.d_data));
    if (ifb.d_wren) mon_pop((1 << 16) | (int'(ifb.d_addr) << 8) | int'(ifb.d_data));
    if (ifc.d_wren) mon_pop((2 << 16) | (int'(ifc.d_addr) << 8) | int'(ifc.d_data));
  end

  // ---------------- reference model ----------------
  function automatic bit is_valid(input int b);
    return (b >= 'h61 && b <= 'h7A) || b == 'h20;
  endfunction

  // textbook RC4 keystream for a w-bit alphabet
  task automatic rc4_model(input int w, input int kb, input int key, input int mlen);
    int n, i, j, t;
    int s [256];
    int kw [4];
    n = 1 << w;
    for (int b = 0; b < kb; b++) kw[b] = (key >> ((kb - 1 - b) * w)) & (n - 1);
    for (int a = 0; a < n; a++) s[a] = a;
    j = 0;
    for (int a = 0; a < n; a++) begin
      j = (j + s[a] + kw[a % kb]) % n;
      t = s[a]; s[a] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int m = 0; m < mlen; m++) begin
      i = (i + 1) % n;
      j = (j + s[i]) % n;
      t = s[i]; s[i] = s[j]; s[j] = t;
      ks[m] = s[(s[i] + s[j]) % n];
    end
  endtask

  // queue the writes the run should produce; return latency and verdict
  task automatic expect_run(input int sel, input int w, input int mlen, input int chk,
                            output int lat, output bit ok);
    int n, pt;
    n   = 1 << w;
    ok  = 1'b1;
    lat = 7 * n + 9 * mlen;
    for (int m = 0; m < mlen; m++) begin
      pt = (rom_img[m] ^ ks[m]) & (n - 1);
      exp_q.push_back((sel << 16) | (m << 8) | pt);
      if (chk != 0 && !is_valid(pt)) begin
        ok  = 1'b0;
        lat = 7 * n + 9 * (m + 1);
        break;
      end
    end
  endtask

  // copy rom_img into the chosen ROM; scramble its S RAM and decrypted RAM
  task automatic load(input int sel);
    case (sel)
      0: for (int a = 0; a < 256; a++) begin
           rom_a[a] = 8'(rom_img[a]); sm_a[a] = 8'($urandom); dm_a[a] = 8'($urandom);
         end
      1: for (int a = 0; a < 256; a++) begin
           rom_b[a] = 8'(rom_img[a]); sm_b[a] = 8'($urandom); dm_b[a] = 8'($urandom);
         end
      default: for (int a = 0; a < 16; a++) begin
           rom_c[a] = 4'(rom_img[a]); sm_c[a] = 4'($urandom); dm_c[a] = 4'($urandom);
         end
    endcase
  endtask

  task automatic run(input int sel, input int key, input int lat, input bit ok, input bit toggle);
    int cyc;
    bit held, ident;
    case (sel)
      0: key_a = 24'(key);
      1: key_b = 24'(key);
      default: key_c = 8'(key);
    endcase
    start_v[sel] = 1'b1;
    @(posedge clk); #1;                       // acceptance edge
    check("busy_on", busy_v[sel], 1);
    cyc = 0;
    while (!done_v[sel] && cyc < 4000) begin
      if (toggle) start_v[sel] = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
      if (sel == 2 && cyc == 16) begin
        ident = 1'b1;
        for (int a = 0; a < 16; a++) if (int'(sm_c[a]) != a) ident = 1'b0;
        check("s_after_init", ident, 1);
      end
    end
    check("done_latency", cyc, lat);
    check("key_ok", kok_v[sel], ok);
    check("busy_off", busy_v[sel], 0);
    start_v[sel] = 1'b1;
    held = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      if (!done_v[sel] || kok_v[sel] != ok) held = 1'b0;
    end
    check("done_hold", held, 1);
    start_v[sel] = 1'b0;
    @(posedge clk); #1;
    check("done_clear", {done_v[sel], kok_v[sel]}, 0);
    check("sb_drain", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  int  ct_rom [9] = '{'hBB, 'hF3, 'h16, 'hE8, 'hD9, 'h40, 'hAF, 'h0A, 'hD3};
  int  ct_pt  [9] = '{'h50, 'h6C, 'h61, 'h69, 'h6E, 'h74, 'h65, 'h78, 'h74};
  int  abc    [9] = '{'h61, 'h62, 'h63, 'h20, 'h78, 'h79, 'h7A, 'h20, 'h20};

  initial begin
    int lat, key, v;
    bit ok;
    reset   = 1'b1;
    start_v = '0;
    key_a = '0; key_b = '0; key_c = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", |{ifa.busy, ifa.done, ifa.key_ok, ifa.s_wren, ifa.d_wren,
                       ifa.s_addr, ifa.s_data, ifa.rom_addr, ifa.d_addr, ifa.d_data}, 0);
    check("reset_c", |{ifc.busy, ifc.done, ifc.key_ok, ifc.s_wren, ifc.d_wren,
                       ifc.s_addr, ifc.s_data, ifc.rom_addr, ifc.d_addr, ifc.d_data}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // A: known vector, 'P' fails the check on the first word
    for (int a = 0; a < 256; a++) rom_img[a] = (a < 9) ? ct_rom[a] : int'($urandom_range(255));
    rc4_model(8, 3, 'h4B6579, 9);
    load(0);
    expect_run(0, 8, 9, 1, lat, ok);
    run(0, 'h4B6579, lat, ok, 1'b0);

    // A: "abc xyz  " passes every word
    for (int a = 0; a < 9; a++) rom_img[a] = abc[a] ^ ks[a];
    load(0);
    expect_run(0, 8, 9, 1, lat, ok);
    run(0, 'h4B6579, lat, ok, 1'b0);

    // A: random keys, mostly-text plaintext so aborts land anywhere
    repeat (3) begin
      key = int'($urandom_range(24'hFFFFFF));
      rc4_model(8, 3, key, 9);
      for (int a = 0; a < 256; a++) rom_img[a] = int'($urandom_range(255));
      for (int a = 0; a < 9; a++) begin
        if ($urandom_range(9) < 8) begin
          v = int'($urandom_range(26));
          v = (v == 26) ? 'h20 : 'h61 + v;
        end else v = int'($urandom_range(255));
        rom_img[a] = v ^ ks[a];
      end
      load(0);
      expect_run(0, 8, 9, 1, lat, ok);
      run(0, key, lat, ok, 1'b0);
    end

    // B: known vector without check -> full "Plaintext"
    for (int a = 0; a < 256; a++) rom_img[a] = (a < 9) ? ct_rom[a] : int'($urandom_range(255));
    rc4_model(8, 3, 'h4B6579, 9);
    load(1);
    expect_run(1, 8, 9, 0, lat, ok);
    run(1, 'h4B6579, lat, ok, 1'b0);
    for (int a = 0; a < 9; a++) check("plaintext", int'(dm_b[a]), ct_pt[a]);

    // B: reset at edge 500 after acceptance (mid-KSA)
    key_b = 24'h4B6579;
    start_v[1] = 1'b1;
    @(posedge clk);
    repeat (499) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("reset_midrun", |{ifb.busy, ifb.done, ifb.key_ok, ifb.s_wren, ifb.d_wren,
                            ifb.s_addr, ifb.s_data, ifb.rom_addr, ifb.d_addr, ifb.d_data}, 0);
    reset = 1'b0;
    start_v[1] = 1'b0;
    @(posedge clk); #1;

    // B: fresh run reproduces the vector; start toggles while busy
    load(1);
    expect_run(1, 8, 9, 0, lat, ok);
    run(1, 'h4B6579, lat, ok, 1'b1);
    for (int a = 0; a < 9; a++) check("plaintext_rerun", int'(dm_b[a]), ct_pt[a]);

    // C: narrow random runs
    repeat (4) begin
      key = int'($urandom_range(255));
      rc4_model(4, 2, key, 4);
      for (int a = 0; a < 256; a++) rom_img[a] = int'($urandom_range(15));
      load(2);
      expect_run(2, 4, 4, 0, lat, ok);
      run(2, key, lat, ok, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
